// File: rtl/qlearn_pkg.sv
// Shared constants and FSM state encoding for the Q-learning update controller.
package qlearn_pkg;

   localparam int unsigned STATES        = 16;
   localparam int unsigned ACTIONS       = 4;
   localparam int unsigned STATES_WIDTH  = 4;
   localparam int unsigned ACTIONS_WIDTH = 2;
   localparam int unsigned DATA_WIDTH    = 16;
   localparam int unsigned ALPHA_SHIFT   = 2;
   localparam int unsigned GAMMA_SHIFT   = 3;

   // Two guard bits hold r + max without overflow before the final reduction.
   localparam int unsigned CALC_WIDTH    = DATA_WIDTH + 2;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StRead  = 3'd1;
   localparam state_t StLoad  = 3'd2;
   localparam state_t StMax   = 3'd3;
   localparam state_t StCalc  = 3'd4;
   localparam state_t StWrite = 3'd5;
   localparam state_t StDone  = 3'd6;

endpackage

// File: rtl/qlearn_max_unit.sv
// Serial signed max over one action row: load captures the row and seeds the max with
// entry 0, then each enabled cycle compares the next entry.
module qlearn_max_unit
   import qlearn_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_load,
   input  logic                            i_en,
   input  logic [DATA_WIDTH*ACTIONS-1:0]   i_row,
   output logic signed [DATA_WIDTH-1:0]    o_max,
   output logic                            o_last
);

   logic signed [DATA_WIDTH-1:0] row_q [ACTIONS];
   logic signed [DATA_WIDTH-1:0] max_q;
   logic [ACTIONS_WIDTH-1:0]     idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ACTIONS; i++) row_q[i] <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else if (i_load) begin
         for (int i = 0; i < ACTIONS; i++) row_q[i] <= i_row[i*DATA_WIDTH +: DATA_WIDTH];
         max_q <= $signed(i_row[DATA_WIDTH-1:0]);
         idx_q <= ACTIONS_WIDTH'(1);
      end else if (i_en) begin
         // Strictly greater keeps the lowest index on ties.
         if (row_q[idx_q] > max_q) max_q <= row_q[idx_q];
         if (!o_last) idx_q <= idx_q + ACTIONS_WIDTH'(1);
      end
   end

   assign o_last = (idx_q == ACTIONS_WIDTH'(ACTIONS - 1));
   assign o_max  = max_q;

endmodule

// File: rtl/qlearn_update_ctrl.sv
// One Q-learning update: read Q(s,a) and row Q(s',.), serial max, shift-based update, write.
// Define QLEARN_SAT_EN to saturate the new Q value instead of wrapping it.
module qlearn_update_ctrl
   import qlearn_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_start,
   input  logic [STATES_WIDTH-1:0]         i_st,
   input  logic [ACTIONS_WIDTH-1:0]        i_at,
   input  logic [STATES_WIDTH-1:0]         i_next_st,
   input  logic [DATA_WIDTH-1:0]           i_reward,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [DATA_WIDTH-1:0]           o_q_new,
   output logic                            o_ram_re,
   output logic                            o_ram_we,
   output logic [STATES_WIDTH-1:0]         o_ram_st,
   output logic [ACTIONS_WIDTH-1:0]        o_ram_at,
   output logic [STATES_WIDTH-1:0]         o_ram_next_st,
   output logic [DATA_WIDTH-1:0]           o_ram_data,
   input  logic [DATA_WIDTH-1:0]           i_ram_q,
   input  logic [DATA_WIDTH*ACTIONS-1:0]   i_ram_next_q
);

   state_t                    state_q, state_d;
   logic [STATES_WIDTH-1:0]   st_q, next_st_q;
   logic [ACTIONS_WIDTH-1:0]  at_q;
   logic [DATA_WIDTH-1:0]     reward_q, q_cur_q, q_new_q, q_red;

   logic signed [DATA_WIDTH-1:0] max_val;
   logic                         max_last;

   logic signed [CALC_WIDTH-1:0] r_e, m_e, q_e, target, delta, q_calc;

   qlearn_max_unit u_max (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (state_q == StLoad),
      .i_en   (state_q == StMax),
      .i_row  (i_ram_next_q),
      .o_max  (max_val),
      .o_last (max_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (i_start) state_d = StRead;
         StRead:  state_d = StLoad;
         StLoad:  state_d = StMax;
         StMax:   if (max_last) state_d = StCalc;
         StCalc:  state_d = StWrite;
         StWrite: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign r_e    = {{2{reward_q[DATA_WIDTH-1]}}, reward_q};
   assign m_e    = {{2{max_val[DATA_WIDTH-1]}}, max_val};
   assign q_e    = {{2{q_cur_q[DATA_WIDTH-1]}}, q_cur_q};
   assign target = r_e + m_e - (m_e >>> GAMMA_SHIFT);
   assign delta  = target - q_e;
   assign q_calc = q_e + (delta >>> ALPHA_SHIFT);

`ifdef QLEARN_SAT_EN
   always_comb begin
      q_red = q_calc[DATA_WIDTH-1:0];
      // Out of range when the guard bits disagree with the result sign bit.
      if (q_calc[CALC_WIDTH-1:DATA_WIDTH-1] != '0 && q_calc[CALC_WIDTH-1:DATA_WIDTH-1] != '1) begin
         q_red = q_calc[CALC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end
`else
   logic unused_guard;
   assign unused_guard = ^q_calc[CALC_WIDTH-1:DATA_WIDTH];
   assign q_red        = q_calc[DATA_WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         st_q      <= '0;
         at_q      <= '0;
         next_st_q <= '0;
         reward_q  <= '0;
         q_cur_q   <= '0;
         q_new_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && i_start) begin
            st_q      <= i_st;
            at_q      <= i_at;
            next_st_q <= i_next_st;
            reward_q  <= i_reward;
         end
         if (state_q == StLoad) q_cur_q <= i_ram_q;
         if (state_q == StCalc) q_new_q <= q_red;
      end
   end

   assign o_busy        = (state_q != StIdle);
   assign o_done        = (state_q == StDone);
   assign o_ram_re      = (state_q == StRead);
   assign o_ram_we      = (state_q == StWrite);
   assign o_q_new       = q_new_q;
   assign o_ram_data    = q_new_q;
   assign o_ram_st      = st_q;
   assign o_ram_at      = at_q;
   assign o_ram_next_st = next_st_q;

endmodule

// File: tb/tb_qlearn_update_ctrl.sv
// Directed bench for qlearn_update_ctrl with a one-cycle-latency action RAM model.
module tb_qlearn_update_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [3:0]  i_st = '0, i_next_st = '0;
   logic [1:0]  i_at = '0;
   logic [15:0] i_reward = '0;
   logic        o_busy, o_done, o_ram_re, o_ram_we;
   logic [15:0] o_q_new, o_ram_data;
   logic [3:0]  o_ram_st, o_ram_next_st;
   logic [1:0]  o_ram_at;
   logic [15:0] i_ram_q;
   logic [63:0] i_ram_next_q;

   logic signed [15:0] tq;
   logic signed [15:0] trow [4];

   int checks = 0;
   int failures = 0;
   int re_cnt = 0, we_cnt = 0, done_cnt = 0, overlap_cnt = 0;
   logic signed [15:0] wr_data;
   logic [3:0] wr_st, rd_nst;
   logic [1:0] wr_at;

   qlearn_update_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_st          (i_st),
      .i_at          (i_at),
      .i_next_st     (i_next_st),
      .i_reward      (i_reward),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_q_new       (o_q_new),
      .o_ram_re      (o_ram_re),
      .o_ram_we      (o_ram_we),
      .o_ram_st      (o_ram_st),
      .o_ram_at      (o_ram_at),
      .o_ram_next_st (o_ram_next_st),
      .o_ram_data    (o_ram_data),
      .i_ram_q       (i_ram_q),
      .i_ram_next_q  (i_ram_next_q)
   );

   always #5 clk = ~clk;

   // RAM answers one cycle after re and returns junk otherwise.
   always @(posedge clk) begin
      if (o_ram_re) begin
         i_ram_q <= tq;
         for (int i = 0; i < 4; i++) i_ram_next_q[i*16 +: 16] <= trow[i];
      end else begin
         i_ram_q      <= 16'h5a5a;
         i_ram_next_q <= {4{16'h4321}};
      end
   end

   always @(negedge clk) begin
      if (o_ram_re) begin
         re_cnt++;
         rd_nst = o_ram_next_st;
      end
      if (o_ram_we) begin
         we_cnt++;
         wr_data = o_ram_data;
         wr_st   = o_ram_st;
         wr_at   = o_ram_at;
      end
      if (o_done) done_cnt++;
      if (o_ram_re && o_ram_we) overlap_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run_update(input string tag, input logic [3:0] st, input logic [1:0] at,
                             input logic [3:0] nst, input logic signed [15:0] r,
                             input logic signed [15:0] q, input logic signed [15:0] r0,
                             input logic signed [15:0] r1, input logic signed [15:0] r2,
                             input logic signed [15:0] r3, input logic signed [15:0] exp_q,
                             input bit inject);
      int n;
      int re0, we0, done0;
      @(negedge clk);
      re0 = re_cnt; we0 = we_cnt; done0 = done_cnt;
      tq = q; trow[0] = r0; trow[1] = r1; trow[2] = r2; trow[3] = r3;
      i_st = st; i_at = at; i_next_st = nst; i_reward = r; i_start = 1'b1;
      @(posedge clk);
      n = 0;
      while (n <= 20) begin
         @(negedge clk);
         n++;
         if (n == 1) i_start = 1'b0;
         if (n == 2) check({tag, "_busy"}, int'(o_busy), 1);
         if (inject && n == 3) begin
            i_st = 4'd9; i_at = 2'd2; i_next_st = 4'd11; i_reward = 16'd1000; i_start = 1'b1;
         end
         if (inject && n == 4) i_start = 1'b0;
         if (o_done) break;
      end
      check({tag, "_lat"}, n, 8);
      @(negedge clk);
      check({tag, "_idle"}, int'(o_busy), 0);
      check({tag, "_re"}, re_cnt - re0, 1);
      check({tag, "_we"}, we_cnt - we0, 1);
      check({tag, "_done"}, done_cnt - done0, 1);
      check({tag, "_wdata"}, int'(wr_data), int'(exp_q));
      check({tag, "_qnew"}, int'($signed(o_q_new)), int'(exp_q));
      check({tag, "_wst"}, int'(wr_st), int'(st));
      check({tag, "_wat"}, int'(wr_at), int'(at));
      check({tag, "_rnst"}, int'(rd_nst), int'(nst));
   endtask

   initial begin
      logic signed [15:0] ovf_exp;
      int we0, done0;
`ifdef QLEARN_SAT_EN
      ovf_exp = 16'sd32767;
`else
      ovf_exp = -16'sd25607;
`endif
      tq = '0;
      for (int i = 0; i < 4; i++) trow[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_outs", int'({o_busy, o_done, o_ram_re, o_ram_we, o_ram_st, o_ram_at,
                              o_ram_next_st}), 0);
      check("rst_qnew", int'(o_q_new), 0);
      check("rst_data", int'(o_ram_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", int'(o_busy), 0);

      run_update("zero", 4'd3, 2'd1, 4'd5, 16'sd64, 16'sd0, 0, 0, 0, 0, 16'sd16, 1'b0);
      run_update("floor", 4'd7, 2'd2, 4'd9, 16'sd0, 16'sd100, 16'sd8, 16'sd80, -16'sd5,
                 16'sd40, 16'sd92, 1'b0);
      run_update("ovf", 4'd12, 2'd0, 4'd13, 16'sd32767, 16'sd32760, 16'sd32767, 16'sd32767,
                 16'sd32767, 16'sd32767, ovf_exp, 1'b0);
      run_update("tie", 4'd2, 2'd3, 4'd2, 16'sd8, -16'sd20, -16'sd3, -16'sd1, -16'sd1,
                 -16'sd7, -16'sd13, 1'b0);
      run_update("last", 4'd15, 2'd3, 4'd14, 16'sd0, 16'sd0, 16'sd1, 16'sd2, 16'sd3,
                 16'sd100, 16'sd22, 1'b0);
      run_update("busy", 4'd4, 2'd0, 4'd6, -16'sd40, 16'sd40, 16'sd10, 16'sd20, 16'sd30,
                 -16'sd50, 16'sd26, 1'b1);

      // Abort in MAX: reset clears everything, nothing is written.
      @(negedge clk);
      we0 = we_cnt; done0 = done_cnt;
      tq = 16'sd7; i_st = 4'd10; i_at = 2'd1; i_next_st = 4'd8; i_reward = 16'd500;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_outs", int'({o_busy, o_done, o_ram_re, o_ram_we, o_ram_st, o_ram_at,
                                o_ram_next_st}), 0);
      check("abort_qnew", int'({o_q_new, o_ram_data}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_we", we_cnt - we0, 0);
      check("abort_done", done_cnt - done0, 0);
      check("abort_idle", int'(o_busy), 0);

      run_update("post", 4'd1, 2'd1, 4'd1, -16'sd4, -16'sd100, -16'sd8, -16'sd8, -16'sd8,
                 -16'sd8, -16'sd78, 1'b0);
      check("overlap", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qlearn_update_ctrl.md
Name: qlearn_update_ctrl

Overview:
- Sequences one Q-learning update on the shared Q-table action RAM.
- Flow: read Q(s,a) and the next-state action row, find max Q(s',·), compute the new Q value, write it back, pulse done.
- Sits between the agent/episode logic (start, state, action, reward) and the action RAM read/write port.
- Shift-based fixed point; no multipliers.

Parameters:
- STATES, 16, number of states
- ACTIONS, 4, number of actions (>=2)
- STATES_WIDTH, 4, state index width
- ACTIONS_WIDTH, 2, action index width
- DATA_WIDTH, 16, signed two's-complement Q/reward width
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT
- GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  request an update; sampled only in IDLE
- i_st  in  STATES_WIDTH  current state s
- i_at  in  ACTIONS_WIDTH  action taken a
- i_next_st  in  STATES_WIDTH  next state s'
- i_reward  in  DATA_WIDTH  signed reward r
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the write has completed
- o_q_new  out  DATA_WIDTH  last written Q value, held until the next CALC
- o_ram_re  out  1  RAM read enable
- o_ram_we  out  1  RAM write enable
- o_ram_st  out  STATES_WIDTH  latched s
- o_ram_at  out  ACTIONS_WIDTH  latched a
- o_ram_next_st  out  STATES_WIDTH  latched s'
- o_ram_data  out  DATA_WIDTH  write data (equals o_q_new)
- i_ram_q  in  DATA_WIDTH  Q(s,a); valid the cycle after re
- i_ram_next_q  in  DATA_WIDTH*ACTIONS  Q(s',·) row, action 0 in LSBs; valid the cycle after re

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0.
- Reset asserted mid-operation aborts immediately. No write and no done are issued.
- FSM sequence: IDLE → READ → LOAD → MAX → CALC → WRITE → DONE → IDLE.
- IDLE:
  - If i_start=1, latch i_st, i_at, i_next_st and i_reward, then go to READ.
  - i_start in any other state is ignored and is not queued.
- READ (1 cycle): o_ram_re=1.
- LOAD (1 cycle): capture i_ram_q and i_ram_next_q into local registers. Set max = action-0 entry and idx = 1.
- MAX (ACTIONS-1 cycles):
  - Each cycle compare one entry, signed; max updates only on strictly greater.
  - On ties the lowest index wins.
  - Move to CALC after idx = ACTIONS-1.
- CALC (1 cycle), all arithmetic in signed DATA_WIDTH+2 bits with sign extension:
  - target = r + max - (max >>> GAMMA_SHIFT)
  - delta = target - Q
  - q_new = Q + (delta >>> ALPHA_SHIFT), with arithmetic shift (floor).
  - q_new is reduced to DATA_WIDTH as described under Optional Feature.
  - The result is registered into o_q_new.
- WRITE (1 cycle): o_ram_we=1, o_ram_data=o_q_new, addresses held.
- DONE (1 cycle): o_done=1, then IDLE.
- Latency: o_done is high ACTIONS+4 cycles after the clock edge that sampled i_start. For ACTIONS=4 that is 8 cycles.
- Minimum start-to-start interval: ACTIONS+5 cycles.
- Address outputs are stable from READ through DONE.
- o_ram_re and o_ram_we are never high in the same cycle.
- s == s' is legal. The max uses the pre-update row.

Optional Feature:
- Macro: QLEARN_SAT_EN
- Defined: the q_new reduction saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: the q_new reduction truncates to the low DATA_WIDTH bits (two's-complement wrap).

Decomposition:
- Shared package qlearn_pkg holds STATES, ACTIONS, the widths, ALPHA_SHIFT, GAMMA_SHIFT and the FSM state enum type.
- Sub-module qlearn_max_unit holds the serial max comparator: start/load, index counter, running max, last flag.
- The FSM and datapath arithmetic stay in the top.

Test Plan (DATA_WIDTH=16, ACTIONS=4, ALPHA_SHIFT=2, GAMMA_SHIFT=3):
- Zero-row update:
  - Stimulus: Q=0, r=64, row {0,0,0,0}.
  - Required: o_ram_we with data 16; o_done exactly 8 cycles after start.
- Negative floor:
  - Stimulus: Q=100, r=0, row {8,80,-5,40}.
  - Required: max 80, target 70, delta -30, written value 92.
- Overflow:
  - Stimulus: Q=32760, r=32767, row all 32767.
  - Required with QLEARN_SAT_EN: write 32767.
  - Required without QLEARN_SAT_EN: write -25607.
- Busy behaviour:
  - Stimulus: assert i_start during MAX with different s/a.
  - Required: ignored; the first update's addresses are written; exactly one o_done.
- Abort:
  - Stimulus: rst_n low during MAX.
  - Required: no o_ram_we; all outputs 0; a following start completes normally.
- All-negative row with tie:
  - Stimulus: row {-3,-1,-1,-7}.
  - Required: max -1, taken from index 1; o_ram_re high exactly 1 cycle per update.
